fetch_stage: RTL

Instruction fetch stage and IF/ID pipeline register for the RISC-V core. It holds the PC and issues word requests to instruction memory over a req/ack handshake. It absorbs stalls with a one-entry buffer, flushes on branch/JAL redirect, and presents the registered instruction, its PC and its opcode field to the Decoder (`ifid_op_o` drives `instr_op_i`).

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 34 +++
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: bubble instruction, major opcodes,
// fetch-stage state encoding and the default reset PC.
package riscv_pkg;

  // Canonical bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcode field values (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Default PC after reset (word aligned)
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {pc, instr} skid register that catches a fetched word while the
// IF/ID register is held by a stall. Clear wins over load.
module fetch_buffer #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [31:0]         instr_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [31:0]         instr_o
);

  // Occupancy flag: the only state that needs a defined reset value
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
    end
  end

  // Payload capture; contents are meaningless while valid_o is low
  always_ff @(posedge clk_i) begin
    if (load_i && !clear_i) begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Issues word requests
// over a req/ack handshake, parks one word in a skid buffer during stalls and
// flushes on redirect, draining any request still outstanding at the time.
module fetch_stage #(
  parameter int                 PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(riscv_pkg::DEFAULT_RESET_PC),
  parameter logic [31:0]        NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                ifid_valid_o,
  output logic [PC_WIDTH-1:0] ifid_pc_o,
  output logic [31:0]         ifid_instr_o,
  output logic [6:0]          ifid_op_o
);

  import riscv_pkg::*;

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] drain_addr_q;
  logic [PC_WIDTH-1:0] redirect_target;

  logic                ack;
  logic                ifid_free;
  logic                ifid_load_mem;
  logic                ifid_load_buf;
  logic                flush;
  logic                capture_drain;

  logic                buf_load;
  logic                buf_clear;
  logic                buf_valid;
  logic [PC_WIDTH-1:0] buf_pc;
  logic [31:0]         buf_instr;

  // Target is forced to a word boundary; mask keeps every input bit in use
  assign redirect_target = redirect_pc_i & ~PC_WIDTH'(3);
  assign ack             = imem_ack_i && imem_req_o;
  assign ifid_free       = !ifid_valid_o || !stall_i;
  assign ifid_op_o       = ifid_instr_o[6:0];

  // Request outputs: DRAIN replays the abandoned address so it stays stable
  always_comb begin
    imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  end

  // Next-state, PC and datapath steering; redirect overrides everything
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_load_mem = 1'b0;
    ifid_load_buf = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    flush         = 1'b0;
    capture_drain = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (ack) begin
          pc_d = pc_q + PC_WIDTH'(4);
          if (ifid_free) begin
            ifid_load_mem = 1'b1;
          end else begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          ifid_load_buf = 1'b1;
          buf_clear     = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (ack) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect_i) begin
      pc_d          = redirect_target;
      flush         = 1'b1;
      buf_clear     = 1'b1;
      buf_load      = 1'b0;
      ifid_load_mem = 1'b0;
      ifid_load_buf = 1'b0;
      case (state_q)
        ST_FETCH: begin
          // Unacked request must be completed before the target is fetched
          state_d       = ack ? ST_FETCH : ST_DRAIN;
          capture_drain = !ack;
        end
        ST_DRAIN: begin
          state_d = ack ? ST_FETCH : ST_DRAIN;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Sequencer state and fetch PC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Address of the request being drained after a redirect
  always_ff @(posedge clk_i) begin
    if (capture_drain) begin
      drain_addr_q <= pc_q;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= NOP_INSTR;
    end else if (flush) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end else if (ifid_load_mem) begin
      ifid_valid_o <= 1'b1;
      ifid_pc_o    <= pc_q;
      ifid_instr_o <= imem_rdata_i;
    end else if (ifid_load_buf) begin
      ifid_valid_o <= 1'b1;
      ifid_pc_o    <= buf_pc;
      ifid_instr_o <= buf_instr;
    end else if (!stall_i) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end
  end

  fetch_buffer #(
    .PC_WIDTH(PC_WIDTH)
  ) u_fetch_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata_i),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .instr_o (buf_instr)
  );

endmodule
